// File: rtl/hack_ctrl_if.sv
// Memory-side bundle for hack_ctrl: instruction fetch port and data port,
// each a level req held until a single-cycle ack.
interface hack_ctrl_if;
   logic        imem_req;
   logic [14:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [14:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/hack_ctrl.sv
// Multi-cycle Hack CPU sequencer: owns A/D/PC/IR, drives the external ALU,
// fetches over the imem port and reads/writes M over the dmem port.
module hack_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   hack_ctrl_if.master mem,
   output logic [15:0] alu_x_o,
   output logic [15:0] alu_y_o,
   output logic        alu_zx_o,
   output logic        alu_nx_o,
   output logic        alu_zy_o,
   output logic        alu_ny_o,
   output logic        alu_f_o,
   output logic        alu_no_o,
   input  logic [15:0] alu_out_i,
   output logic [14:0] pc_o,
   output logic [15:0] a_reg_o,
   output logic [15:0] d_reg_o,
   output logic        retire_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_MEMRD  = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [14:0] pc_q,  pc_d;
   logic [15:0] a_q,   a_d;
   logic [15:0] d_q,   d_d;
   logic [15:0] ir_q,  ir_d;
   logic [15:0] mdr_q, mdr_d;
   logic [15:0] res_q, res_d;
   logic        jmp_q, jmp_d;
   logic        retire_s;

   function automatic logic jump_taken(input logic [2:0] jbits, input logic [15:0] val);
      logic zr;
      logic ng;
      zr = (val == 16'h0000);
      ng = val[15];
      return (jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & ~zr & ~ng);
   endfunction

   // State and architectural registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= 15'd0;
         a_q     <= 16'h0000;
         d_q     <= 16'h0000;
         ir_q    <= 16'h0000;
         mdr_q   <= 16'h0000;
         res_q   <= 16'h0000;
         jmp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         d_q     <= d_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         res_q   <= res_d;
         jmp_q   <= jmp_d;
      end
   end

   // Next-state, register updates and the commit pulse.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      a_d      = a_q;
      d_d      = d_q;
      ir_d     = ir_q;
      mdr_d    = mdr_q;
      res_d    = res_q;
      jmp_d    = jmp_q;
      retire_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem.imem_ack) begin
               ir_d    = mem.imem_rdata;
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            if (!ir_q[15]) begin
               a_d      = ir_q;
               pc_d     = pc_q + 15'd1;
               retire_s = 1'b1;
               state_d  = S_FETCH;
            end else if (ir_q[12]) begin
               state_d = S_MEMRD;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_MEMRD: begin
            if (mem.dmem_ack) begin
               mdr_d   = mem.dmem_rdata;
               state_d = S_EXEC;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_EXEC: begin
            res_d   = alu_out_i;
            jmp_d   = jump_taken(ir_q[2:0], alu_out_i);
            state_d = S_WB;
         end
         S_WB: begin
            // Jump target and stores use the A value from before this commit.
            if (!ir_q[3] || mem.dmem_ack) begin
               retire_s = 1'b1;
               if (ir_q[5]) begin
                  a_d = res_q;
               end else begin
                  a_d = a_q;
               end
               if (ir_q[4]) begin
                  d_d = res_q;
               end else begin
                  d_d = d_q;
               end
               if (jmp_q) begin
                  pc_d = a_q[14:0];
               end else begin
                  pc_d = pc_q + 15'd1;
               end
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem.imem_req   = (state_q == S_FETCH);
   assign mem.imem_addr  = pc_q;
   assign mem.dmem_req   = (state_q == S_MEMRD) || ((state_q == S_WB) && ir_q[3]);
   assign mem.dmem_we    = (state_q == S_WB) && ir_q[3];
   assign mem.dmem_addr  = a_q[14:0];
   assign mem.dmem_wdata = res_q;

   assign alu_x_o  = d_q;
   assign alu_y_o  = ir_q[12] ? mdr_q : a_q;
   assign alu_zx_o = ir_q[11];
   assign alu_nx_o = ir_q[10];
   assign alu_zy_o = ir_q[9];
   assign alu_ny_o = ir_q[8];
   assign alu_f_o  = ir_q[7];
   assign alu_no_o = ir_q[6];

   assign pc_o     = pc_q;
   assign a_reg_o  = a_q;
   assign d_reg_o  = d_q;
   assign retire_o = retire_s;

endmodule

// File: tb/tb_hack_ctrl.sv
// Directed bench for hack_ctrl: behavioural ALU and memories, scoreboards for
// committed state and memory transactions.
module tb_hack_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   hack_ctrl_if mem ();

   logic [15:0] alu_x, alu_y, alu_out;
   logic        zx, nx, zy, ny, fsel, nout;
   logic [14:0] pc;
   logic [15:0] a_reg, d_reg;
   logic        retire;

   hack_ctrl dut (
      .clk(clk), .rst_n(rst_n), .mem(mem),
      .alu_x_o(alu_x), .alu_y_o(alu_y),
      .alu_zx_o(zx), .alu_nx_o(nx), .alu_zy_o(zy), .alu_ny_o(ny),
      .alu_f_o(fsel), .alu_no_o(nout), .alu_out_i(alu_out),
      .pc_o(pc), .a_reg_o(a_reg), .d_reg_o(d_reg), .retire_o(retire)
   );

   always #5 clk = ~clk;

   // Reference Hack ALU.
   logic [15:0] ax, ay, ar;
   always_comb begin
      ax = alu_x;
      if (zx) ax = 16'h0000;
      if (nx) ax = ~ax;
      ay = alu_y;
      if (zy) ay = 16'h0000;
      if (ny) ay = ~ay;
      ar = fsel ? (ax + ay) : (ax & ay);
      if (nout) ar = ~ar;
      alu_out = ar;
   end

   typedef struct packed {logic [14:0] pc; logic [15:0] a; logic [15:0] d;} ret_t;
   typedef struct packed {logic we; logic [14:0] addr; logic [15:0] data;} xact_t;
   ret_t  exp_q[$];
   xact_t xq[$];
   int    ret_cyc_q[$];

   logic [15:0] imem_mem [0:32767];
   logic [15:0] dmem_mem [0:32767];
   int  n_checks = 0, n_fails = 0;
   int  cyc = 0, rel_cyc = 0, ret_cnt = 0;
   int  iwait = 0, dwait = 0, fetch_budget = 0, icnt = 0, dcnt = 0;
   logic chk_pending = 1'b0;
   logic iack_r = 1'b0, dack_r = 1'b0, dack_extra = 1'b0;
   logic [15:0] irdata_r = 16'h0000, drdata_r = 16'h0000;

   assign mem.imem_ack   = iack_r;
   assign mem.imem_rdata = irdata_r;
   assign mem.dmem_ack   = dack_r | dack_extra;
   assign mem.dmem_rdata = drdata_r;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Instruction memory: acks after iwait cycles while fetch budget remains.
   always @(negedge clk) begin
      if (!rst_n || !mem.imem_req) begin
         iack_r = 1'b0; icnt = 0;
      end else if (icnt >= iwait && fetch_budget > 0) begin
         iack_r = 1'b1; irdata_r = imem_mem[mem.imem_addr];
         fetch_budget--; icnt = 0;
      end else begin
         iack_r = 1'b0; icnt++;
      end
   end

   // Data memory with transaction scoreboard.
   always @(negedge clk) begin
      if (!rst_n || !mem.dmem_req) begin
         dack_r = 1'b0; dcnt = 0;
      end else if (dcnt >= dwait) begin
         xact_t e;
         dack_r = 1'b1; dcnt = 0;
         drdata_r = dmem_mem[mem.dmem_addr];
         if (xq.size() == 0) begin
            check("xact_unexpected", 32'(mem.dmem_req), 32'd0);
         end else begin
            e = xq.pop_front();
            check("xact_we", 32'(mem.dmem_we), 32'(e.we));
            check("xact_addr", 32'(mem.dmem_addr), 32'(e.addr));
            if (e.we) check("xact_wdata", 32'(mem.dmem_wdata), 32'(e.data));
         end
         if (mem.dmem_we) dmem_mem[mem.dmem_addr] = mem.dmem_wdata;
      end else begin
         dack_r = 1'b0; dcnt++;
      end
   end

   // Retire monitor: committed state is compared in the following cycle.
   always @(negedge clk) begin
      #1;
      if (chk_pending) begin
         ret_t e;
         chk_pending = 1'b0;
         e = exp_q.pop_front();
         check("ret_pc", 32'(pc), 32'(e.pc));
         check("ret_a", 32'(a_reg), 32'(e.a));
         check("ret_d", 32'(d_reg), 32'(e.d));
      end
      if (rst_n && retire) begin
         ret_cyc_q.push_back(cyc);
         ret_cnt++;
         if (exp_q.size() == 0) check("retire_unexpected", 32'(retire), 32'd0);
         else chk_pending = 1'b1;
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic exp_ret(input logic [14:0] p, input logic [15:0] a, input logic [15:0] d);
      ret_t e;
      e.pc = p; e.a = a; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic exp_x(input logic we, input logic [14:0] addr, input logic [15:0] data);
      xact_t e;
      e.we = we; e.addr = addr; e.data = data;
      xq.push_back(e);
   endtask

   task automatic start_test(input int iw, input int dw, input int budget);
      rst_n = 1'b0;
      iwait = iw; dwait = dw; fetch_budget = budget; dack_extra = 1'b0;
      exp_q.delete(); xq.delete(); ret_cyc_q.delete();
      ret_cnt = 0; chk_pending = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      rel_cyc = cyc;
      check("rst_imem_req", 32'(mem.imem_req), 32'd0);
      check("rst_dmem_req", 32'(mem.dmem_req), 32'd0);
      check("rst_dmem_we", 32'(mem.dmem_we), 32'd0);
      check("rst_retire", 32'(retire), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_a", 32'(a_reg), 32'd0);
      check("rst_d", 32'(d_reg), 32'd0);
      tick();
      check("first_imem_req", 32'(mem.imem_req), 32'd1);
      check("first_imem_addr", 32'(mem.imem_addr), 32'd0);
   endtask

   task automatic run_until(input int n, input int maxc);
      for (int i = 0; i < maxc && ret_cnt < n; i++) tick();
      check("retire_count", 32'(ret_cnt), 32'(n));
   endtask

   task automatic end_test();
      tick(); tick();
      check("ret_sb_empty", 32'(exp_q.size()), 32'd0);
      check("xact_sb_empty", 32'(xq.size()), 32'd0);
   endtask

   logic [15:0] jp1 [5] = '{16'hEA87, 16'hE301, 16'hEDE7, 16'hEA82, 16'hEE84};
   logic [14:0] jpc [5] = '{15'd10, 15'd2, 15'd10, 15'd10, 15'd10};
   logic [15:0] ja  [5] = '{16'd10, 16'd10, 16'd11, 16'd10, 16'd10};

   initial begin
      int held;
      for (int i = 0; i < 32768; i++) begin
         imem_mem[i] = 16'h0000; dmem_mem[i] = 16'h0000;
      end

      // @5 ; D=A
      imem_mem[0] = 16'h0005; imem_mem[1] = 16'hEC10;
      start_test(0, 0, 2);
      exp_ret(15'd1, 16'd5, 16'd0); exp_ret(15'd2, 16'd5, 16'd5);
      run_until(2, 40);
      end_test();
      check("ret_pulses", 32'(ret_cyc_q.size()), 32'd2);
      if (ret_cyc_q.size() == 2) begin
         check("gap_a_instr", 32'(ret_cyc_q[0] - rel_cyc), 32'd2);
         check("gap_c_instr", 32'(ret_cyc_q[1] - ret_cyc_q[0]), 32'd4);
      end
      check("t1_pc", 32'(pc), 32'd2);
      check("t1_a", 32'(a_reg), 32'd5);
      check("t1_d", 32'(d_reg), 32'd5);

      // D=7 ; @100 ; M=D with 3 wait cycles on the data ack
      imem_mem[0] = 16'h0007; imem_mem[1] = 16'hEC10;
      imem_mem[2] = 16'h0064; imem_mem[3] = 16'hE308;
      start_test(0, 3, 4);
      exp_ret(15'd1, 16'd7, 16'd0); exp_ret(15'd2, 16'd7, 16'd7);
      exp_ret(15'd3, 16'd100, 16'd7); exp_ret(15'd4, 16'd100, 16'd7);
      exp_x(1'b1, 15'd100, 16'd7);
      run_until(3, 40);
      for (int i = 0; i < 20 && !mem.dmem_req; i++) tick();
      held = 0;
      while (mem.dmem_req && held < 20) begin
         check("wr_addr", 32'(mem.dmem_addr), 32'd100);
         check("wr_data", 32'(mem.dmem_wdata), 32'd7);
         check("wr_we", 32'(mem.dmem_we), 32'd1);
         check("wr_pc_hold", 32'(pc), 32'd3);
         held++;
         tick();
      end
      check("wr_req_cycles", 32'(held), 32'd4);
      check("wr_pc_after", 32'(pc), 32'd4);
      run_until(4, 10);
      end_test();
      check("wr_mem", 32'(dmem_mem[100]), 32'd7);

      // D=1 ; @100 ; D=D+M with M=0x7FFF
      dmem_mem[100] = 16'h7FFF;
      imem_mem[0] = 16'h0001; imem_mem[1] = 16'hEC10;
      imem_mem[2] = 16'h0064; imem_mem[3] = 16'hF090;
      start_test(1, 1, 4);
      exp_ret(15'd1, 16'd1, 16'd0); exp_ret(15'd2, 16'd1, 16'd1);
      exp_ret(15'd3, 16'd100, 16'd1); exp_ret(15'd4, 16'd100, 16'h8000);
      exp_x(1'b0, 15'd100, 16'h0000);
      run_until(4, 80);
      end_test();
      check("rd_d", 32'(d_reg), 32'h8000);

      // Jumps: @10 followed by one C-instruction each
      for (int k = 0; k < 5; k++) begin
         imem_mem[0] = 16'h000A; imem_mem[1] = jp1[k];
         start_test(0, 0, 2);
         exp_ret(15'd1, 16'd10, 16'd0); exp_ret(jpc[k], ja[k], 16'd0);
         run_until(2, 40);
         end_test();
         check("jmp_pc", 32'(pc), 32'(jpc[k]));
      end

      // PC wrap: jump to 0x7FFF, execute @0 there
      imem_mem[0] = 16'h7FFF; imem_mem[1] = 16'hEA87; imem_mem[32767] = 16'h0000;
      start_test(0, 0, 3);
      exp_ret(15'd1, 16'h7FFF, 16'd0); exp_ret(15'h7FFF, 16'h7FFF, 16'd0);
      exp_ret(15'd0, 16'h0000, 16'd0);
      run_until(3, 40);
      end_test();
      check("wrap_pc", 32'(pc), 32'd0);

      // Reset in the middle of a stalled write
      imem_mem[0] = 16'h0007; imem_mem[1] = 16'hEC10;
      imem_mem[2] = 16'h0064; imem_mem[3] = 16'hE308;
      start_test(0, 1000, 4);
      exp_ret(15'd1, 16'd7, 16'd0); exp_ret(15'd2, 16'd7, 16'd7);
      exp_ret(15'd3, 16'd100, 16'd7);
      run_until(3, 40);
      for (int i = 0; i < 20 && !(mem.dmem_req && mem.dmem_we); i++) tick();
      check("abort_in_wb", 32'(mem.dmem_req && mem.dmem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_dmem_req", 32'(mem.dmem_req), 32'd0);
      check("abort_pc", 32'(pc), 32'd0);
      check("abort_d", 32'(d_reg), 32'd0);
      check("abort_a", 32'(a_reg), 32'd0);
      ret_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      dack_extra = 1'b1;
      #1;
      check("late_ack_retire", 32'(retire), 32'd0);
      @(negedge clk);
      dack_extra = 1'b0;
      #1;
      check("late_ack_pc", 32'(pc), 32'd0);
      check("late_ack_d", 32'(d_reg), 32'd0);
      repeat (5) tick();
      check("late_ack_no_retire", 32'(ret_cnt), 32'd0);
      check("abort_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
